// File: rtl/decrypter.sv
// Iterative 64-bit Feistel block decrypter, receive-side inverse of Encrypter.
// Optional build macro DEC_UNROLL2_EN: two cascaded rounds per clock (latency ROUNDS/2).
module decrypter #(
    parameter int ROUNDS  = 16,
    parameter int KEY_ROT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set,
    input  logic [0:63] data_in,
    input  logic [0:63] key_in,
    output logic [0:63] data_out,
    output logic [0:63] key_out,
    output logic        status
);

    localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int unsigned LOAD_ROT = (KEY_ROT * (ROUNDS - 1)) % 64;
    localparam logic [CW-1:0] CNT_START = CW'(ROUNDS - 1);
`ifdef DEC_UNROLL2_EN
    localparam logic [CW-1:0] CNT_LAST = CW'(1);
    localparam logic [CW-1:0] CNT_DEC  = CW'(2);
`else
    localparam logic [CW-1:0] CNT_LAST = CW'(0);
    localparam logic [CW-1:0] CNT_DEC  = CW'(1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned n);
        int unsigned s;
        s = n % 32'd64;
        return (x << s) | (x >> ((32'd64 - s) % 32'd64));
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
        return rotl64(x, 32'd64 - (n % 32'd64));
    endfunction

    function automatic logic [31:0] f_fn(input logic [31:0] x, input logic [31:0] k);
        return ({x[28:0], x[31:29]} + k) ^ (x >> 5);
    endfunction

    state_t        state_q, state_d;
    logic [31:0]   l_q, l_d, r_q, r_d;
    logic [63:0]   key_q, key_d;
    logic [63:0]   kout_q, kout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          status_q, status_d;

    logic [31:0]   rnd_l_s, rnd_r_s;
    logic [63:0]   key_rot1_s, key_next_s;
    logic [31:0]   l1_s, r1_s;
`ifdef DEC_UNROLL2_EN
    logic [31:0]   rk1_s;
`endif

    // Round datapath: inverse round i from key_q, optionally followed by round i-1.
    always_comb begin
        key_rot1_s = rotr64(key_q, KEY_ROT);
        l1_s       = r_q ^ f_fn(l_q, key_q[63:32]);
        r1_s       = l_q;
`ifdef DEC_UNROLL2_EN
        rk1_s      = key_rot1_s[63:32];
        rnd_l_s    = r1_s ^ f_fn(l1_s, rk1_s);
        rnd_r_s    = l1_s;
        key_next_s = rotr64(key_rot1_s, KEY_ROT);
`else
        rnd_l_s    = l1_s;
        rnd_r_s    = r1_s;
        key_next_s = key_rot1_s;
`endif
    end

    // Next-state logic for the control FSM and all datapath registers.
    always_comb begin
        state_d  = state_q;
        l_d      = l_q;
        r_d      = r_q;
        key_d    = key_q;
        kout_d   = kout_q;
        cnt_d    = cnt_q;
        status_d = status_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (set) begin
                    l_d      = data_in[0:31];
                    r_d      = data_in[32:63];
                    kout_d   = key_in;
                    key_d    = rotl64(key_in, LOAD_ROT);
                    cnt_d    = CNT_START;
                    status_d = 1'b0;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = state_q;
                end
            end
            ST_RUN: begin
                l_d   = rnd_l_s;
                r_d   = rnd_r_s;
                key_d = key_next_s;
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = {CW{1'b0}};
                    status_d = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d    = cnt_q - CNT_DEC;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                status_d = 1'b0;
            end
        endcase
    end

    // State registers; rst clears everything so no partial result survives an abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            l_q      <= 32'd0;
            r_q      <= 32'd0;
            key_q    <= 64'd0;
            kout_q   <= 64'd0;
            cnt_q    <= {CW{1'b0}};
            status_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            l_q      <= l_d;
            r_q      <= r_d;
            key_q    <= key_d;
            kout_q   <= kout_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
        end
    end

    assign data_out = {l_q, r_q};
    assign key_out  = kout_q;
    assign status   = status_q;

endmodule

// File: tb/tb_decrypter.sv
// Directed self-checking bench for decrypter; ciphertexts come from a forward Encrypter model.
module tb_decrypter;

`ifdef DEC_UNROLL2_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 16;
`endif

    localparam logic [63:0] PT1  = 64'h0123456789abcdef;
    localparam logic [63:0] KEY1 = 64'h0102030405060708;
    localparam logic [63:0] PT2  = 64'hfedcba9876543210;
    localparam logic [63:0] KEY2 = 64'h0f1e2d3c4b5a6978;
    localparam logic [63:0] PT3  = 64'hdeadbeefcafef00d;
    localparam logic [63:0] KEY3 = 64'hffffffff00000001;

    logic        clk = 1'b0;
    logic        rst;
    logic        set;
    logic [0:63] data_in;
    logic [0:63] key_in;
    logic [0:63] data_out;
    logic [0:63] key_out;
    logic        status;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decrypter dut (
        .clk      (clk),
        .rst      (rst),
        .set      (set),
        .data_in  (data_in),
        .key_in   (key_in),
        .data_out (data_out),
        .key_out  (key_out),
        .status   (status)
    );

    function automatic logic [63:0] enc_model(input logic [63:0] pt, input logic [63:0] key);
        logic [31:0] l, r, t, rk;
        logic [63:0] kr;
        l = pt[63:32];
        r = pt[31:0];
        for (int i = 0; i < 16; i++) begin
            kr = (i == 0) ? key : ((key << (4 * i)) | (key >> (64 - 4 * i)));
            rk = kr[63:32];
            t  = l ^ ((({r[28:0], r[31:29]}) + rk) ^ (r >> 5));
            l  = r;
            r  = t;
        end
        return {l, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_set(input logic [63:0] d, input logic [63:0] k);
        data_in = d;
        key_in  = k;
        set     = 1'b1;
        tick();
        set     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; set = 1'b0; data_in = 64'd0; key_in = 64'd0;
        tick(); tick();
        n_tests++; if (data_out !== 64'd0) begin n_fail++; $display("FAIL rst_data got %h exp 0", data_out); end
        n_tests++; if (key_out !== 64'd0) begin n_fail++; $display("FAIL rst_key got %h exp 0", key_out); end
        n_tests++; if (status !== 1'b0) begin n_fail++; $display("FAIL rst_status got %b exp 0", status); end
        data_in = enc_model(PT1, KEY1); key_in = KEY1; set = 1'b1;
        tick();
        rst = 1'b0; set = 1'b0;
        n_tests++; if (key_out !== 64'd0) begin n_fail++; $display("FAIL rst_over_set_key got %h exp 0", key_out); end
        for (int c = 0; c < LAT + 1; c++) tick();
        n_tests++; if (status !== 1'b0) begin n_fail++; $display("FAIL rst_over_set_status got %b exp 0", status); end
        n_tests++; if (data_out !== 64'd0) begin n_fail++; $display("FAIL idle_data got %h exp 0", data_out); end
    endtask

    task automatic test_round_trip();
        pulse_set(enc_model(PT1, KEY1), KEY1);
        n_tests++; if (key_out !== KEY1) begin n_fail++; $display("FAIL rt_key_latch got %h exp %h", key_out, KEY1); end
        for (int c = 1; c <= LAT; c++) begin
            tick();
            if (c == LAT - 1) begin
                n_tests++; if (status !== 1'b0) begin n_fail++; $display("FAIL rt_early_status got %b exp 0", status); end
            end
        end
        n_tests++; if (status !== 1'b1) begin n_fail++; $display("FAIL rt_status got %b exp 1", status); end
        n_tests++; if (data_out !== PT1) begin n_fail++; $display("FAIL rt_data got %h exp %h", data_out, PT1); end
        n_tests++; if (key_out !== KEY1) begin n_fail++; $display("FAIL rt_key got %h exp %h", key_out, KEY1); end
        tick(); tick(); tick();
        n_tests++; if (data_out !== PT1 || status !== 1'b1) begin
            n_fail++; $display("FAIL rt_hold got %h/%b exp %h/1", data_out, status, PT1);
        end
    endtask

    task automatic test_zero();
        pulse_set(64'd0, 64'd0);
        for (int c = 1; c < LAT; c++) tick();
        n_tests++; if (status !== 1'b0) begin n_fail++; $display("FAIL zero_early_status got %b exp 0", status); end
        tick();
        n_tests++; if (status !== 1'b1) begin n_fail++; $display("FAIL zero_status got %b exp 1", status); end
        n_tests++; if (data_out !== 64'd0) begin n_fail++; $display("FAIL zero_data got %h exp 0", data_out); end
    endtask

    task automatic test_busy_lockout();
        pulse_set(enc_model(PT1, KEY1), KEY1);
        for (int c = 1; c < 5; c++) tick();
        pulse_set(enc_model(PT2, KEY2), KEY2);
        n_tests++; if (key_out !== KEY1) begin n_fail++; $display("FAIL busy_key got %h exp %h", key_out, KEY1); end
        for (int c = 0; c < LAT - 6; c++) tick();
        n_tests++; if (status !== 1'b0) begin n_fail++; $display("FAIL busy_early_status got %b exp 0", status); end
        tick();
        n_tests++; if (status !== 1'b1) begin n_fail++; $display("FAIL busy_status got %b exp 1", status); end
        n_tests++; if (data_out !== PT1) begin n_fail++; $display("FAIL busy_data got %h exp %h", data_out, PT1); end
    endtask

    task automatic test_back_to_back();
        pulse_set(enc_model(PT2, KEY2), KEY2);
        n_tests++; if (status !== 1'b0) begin n_fail++; $display("FAIL b2b_clear got %b exp 0", status); end
        n_tests++; if (key_out !== KEY2) begin n_fail++; $display("FAIL b2b_key got %h exp %h", key_out, KEY2); end
        for (int c = 1; c <= LAT; c++) tick();
        n_tests++; if (status !== 1'b1 || data_out !== PT2) begin
            n_fail++; $display("FAIL b2b_first got %h/%b exp %h/1", data_out, status, PT2);
        end
        pulse_set(enc_model(PT3, KEY3), KEY3);
        n_tests++; if (status !== 1'b0) begin n_fail++; $display("FAIL b2b_clear2 got %b exp 0", status); end
        for (int c = 1; c <= LAT; c++) tick();
        n_tests++; if (status !== 1'b1 || data_out !== PT3) begin
            n_fail++; $display("FAIL b2b_second got %h/%b exp %h/1", data_out, status, PT3);
        end
    endtask

    task automatic test_reset_mid_run();
        pulse_set(enc_model(PT3, KEY3), KEY3);
        for (int c = 1; c < LAT / 2; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (data_out !== 64'd0) begin n_fail++; $display("FAIL mid_rst_data got %h exp 0", data_out); end
        n_tests++; if (key_out !== 64'd0) begin n_fail++; $display("FAIL mid_rst_key got %h exp 0", key_out); end
        n_tests++; if (status !== 1'b0) begin n_fail++; $display("FAIL mid_rst_status got %b exp 0", status); end
        for (int c = 0; c < LAT + 2; c++) tick();
        n_tests++; if (status !== 1'b0) begin n_fail++; $display("FAIL mid_rst_stale got %b exp 0", status); end
        pulse_set(enc_model(PT1, KEY1), KEY1);
        for (int c = 1; c <= LAT; c++) tick();
        n_tests++; if (status !== 1'b1 || data_out !== PT1) begin
            n_fail++; $display("FAIL mid_rst_rerun got %h/%b exp %h/1", data_out, status, PT1);
        end
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_zero();
        test_busy_lockout();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
